// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the pipelined RV32I core: PC register, next-PC
// selection with stall/flush/misaligned-trap priority, and the IF/ID register.
module fetch_stage #(
  parameter int                        DATA_WIDTH    = 32,
  parameter int                        ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_VECTOR  = '0,
  parameter logic [ADDRESS_WIDTH-1:0]  TRAP_VECTOR   = 16'h0100,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [1:0]               pc_src,
  input  logic [ADDRESS_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0]    ex_imm,
  input  logic [DATA_WIDTH-1:0]    ex_rs1,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    if_id_instr,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc4,
  output logic                     if_id_valid,
  output logic                     misaligned
);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [ADDRESS_WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic                     valid_q, valid_d;
  logic                     misaligned_q, misaligned_d;

  logic [DATA_WIDTH-1:0]    branch_sum;
  logic [DATA_WIDTH-1:0]    jalr_sum;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     redirect;
  logic                     target_misaligned;
  logic                     unused_upper;

  // Sums are formed at full data width and truncated, so PC arithmetic wraps.
  always_comb begin
    branch_sum = DATA_WIDTH'(ex_pc) + ex_imm;
    jalr_sum   = ex_rs1 + ex_imm;
    pc_plus4   = pc_q + ADDRESS_WIDTH'(4);
    redirect   = (pc_src == 2'b01) || (pc_src == 2'b10);
    if (pc_src == 2'b10) begin
      target = jalr_sum[ADDRESS_WIDTH-1:0] & ~ADDRESS_WIDTH'(1);
    end else begin
      target = branch_sum[ADDRESS_WIDTH-1:0];
    end
    target_misaligned = redirect && (target[1:0] != 2'b00);
  end

  assign unused_upper = ^{branch_sum[DATA_WIDTH-1:ADDRESS_WIDTH],
                          jalr_sum[DATA_WIDTH-1:ADDRESS_WIDTH]};

  // Redirect outranks stall: the stalled instruction belongs to the squashed path.
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
    if (redirect) begin
      pc_d         = target_misaligned ? TRAP_VECTOR : target;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      misaligned_d = target_misaligned;
    end else if (!stall) begin
      pc_d     = pc_plus4;
      instr_d  = imem_instr;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_pc4   = id_pc4_q;
  assign if_id_valid = valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the instruction memory returns
// 0xC0DE0000 | address so every fetched word identifies its own PC.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [15:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] imem_instr;
  logic [15:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc4;
  logic        if_id_valid;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_src      (pc_src),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .imem_instr  (imem_instr),
    .imem_addr   (imem_addr),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .misaligned  (misaligned)
  );

  assign imem_instr = 32'hC0DE0000 | {16'h0000, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, clock once, and return at the next falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [1:0] src,
                               input logic [15:0] epc, input logic [31:0] imm,
                               input logic [31:0] rs1);
    rst    = r;
    stall  = s;
    pc_src = src;
    ex_pc  = epc;
    ex_imm = imm;
    ex_rs1 = rs1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [15:0] addr,
                           input logic [31:0] instr, input logic [15:0] pc,
                           input logic [15:0] pc4, input logic valid,
                           input logic mis);
    checkOutput({tag, ".addr"},  {16'h0, imem_addr},   {16'h0, addr});
    checkOutput({tag, ".instr"}, if_id_instr,          instr);
    checkOutput({tag, ".pc"},    {16'h0, if_id_pc},    {16'h0, pc});
    checkOutput({tag, ".pc4"},   {16'h0, if_id_pc4},   {16'h0, pc4});
    checkOutput({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    checkOutput({tag, ".mis"},   {31'h0, misaligned},  {31'h0, mis});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = 2'b00;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("reset", 16'h0000, 32'h00000013, 16'h0000, 16'h0000, 0, 0);

    // Free-running sequential fetch
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("seq1", 16'h0004, 32'hC0DE0000, 16'h0000, 16'h0004, 1, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("seq2", 16'h0008, 32'hC0DE0004, 16'h0004, 16'h0008, 1, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("seq3", 16'h000C, 32'hC0DE0008, 16'h0008, 16'h000C, 1, 0);

    // Backward branch 0x10 - 8 = 0x08: one bubble, pc/pc4 held
    applyStimulus(0, 0, 2'b01, 16'h0010, 32'hFFFFFFF8, 32'h0);
    checkIfId("br.bubble", 16'h0008, 32'h00000013, 16'h0008, 16'h000C, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("br.target", 16'h000C, 32'hC0DE0008, 16'h0008, 16'h000C, 1, 0);

    // JALR 0x203+1 = 0x204, aligned
    applyStimulus(0, 0, 2'b10, 16'h0, 32'h00000001, 32'h00000203);
    checkIfId("jalr.bubble", 16'h0204, 32'h00000013, 16'h0008, 16'h000C, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("jalr.target", 16'h0208, 32'hC0DE0204, 16'h0204, 16'h0208, 1, 0);

    // JALR 0x201+1 = 0x202, bit 0 already clear, bit 1 set: trap
    applyStimulus(0, 0, 2'b10, 16'h0, 32'h00000001, 32'h00000201);
    checkIfId("mis.trap", 16'h0100, 32'h00000013, 16'h0204, 16'h0208, 0, 1);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("mis.after", 16'h0104, 32'hC0DE0100, 16'h0100, 16'h0104, 1, 0);

    // Reach PC 0x20 with 0x1C in IF/ID, then stall three cycles
    applyStimulus(0, 0, 2'b01, 16'h001C, 32'h0, 32'h0);
    checkIfId("pre.stall", 16'h001C, 32'h00000013, 16'h0100, 16'h0104, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("at.0x20", 16'h0020, 32'hC0DE001C, 16'h001C, 16'h0020, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 2'b00, 16'h0, 32'h0, 32'h0);
      checkIfId("stall", 16'h0020, 32'hC0DE001C, 16'h001C, 16'h0020, 1, 0);
    end

    // Redirect during stall wins: 0x40 + 0x10 = 0x50
    applyStimulus(0, 1, 2'b01, 16'h0040, 32'h00000010, 32'h0);
    checkIfId("stall.redir", 16'h0050, 32'h00000013, 16'h001C, 16'h0020, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("stall.tgt", 16'h0054, 32'hC0DE0050, 16'h0050, 16'h0054, 1, 0);

    // pc_src=11 acts as sequential and honours stall
    applyStimulus(0, 1, 2'b11, 16'h0040, 32'h00000010, 32'h0);
    checkIfId("src11.stall", 16'h0054, 32'hC0DE0050, 16'h0050, 16'h0054, 1, 0);
    applyStimulus(0, 0, 2'b11, 16'h0040, 32'h00000010, 32'h0);
    checkIfId("src11.seq", 16'h0058, 32'hC0DE0054, 16'h0054, 16'h0058, 1, 0);

    // Wrap-around from 0xFFF8
    applyStimulus(0, 0, 2'b01, 16'hFFF8, 32'h0, 32'h0);
    checkIfId("wrap.redir", 16'hFFF8, 32'h00000013, 16'h0054, 16'h0058, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("wrap.fff8", 16'hFFFC, 32'hC0DEFFF8, 16'hFFF8, 16'hFFFC, 1, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("wrap.fffc", 16'h0000, 32'hC0DEFFFC, 16'hFFFC, 16'h0000, 1, 0);

    // Reset during a misaligned JALR redirect: neither trap nor target taken
    applyStimulus(1, 1, 2'b10, 16'h0, 32'h00000001, 32'h00000201);
    checkIfId("rst.redir", 16'h0000, 32'h00000013, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(0, 0, 2'b00, 16'h0, 32'h0, 32'h0);
    checkIfId("rst.first", 16'h0004, 32'hC0DE0000, 16'h0000, 16'h0004, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
